// File: rtl/fifo_param_pkg.sv
// Shared op encodings and width helpers for the parametrised FIFO.
package fifo_param_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_IDLE  = 3'd0,
    OP_WR    = 3'd1,
    OP_RD    = 3'd2,
    OP_WRRD  = 3'd3,
    OP_FLUSH = 3'd4
  } op_e;

  // Count must hold 0..DEPTH inclusive, so one bit more than the address.
  function automatic int cntWidth(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_param_if.sv
// Producer/consumer handshake bundle for fifo_param.
// Optional almost_full/almost_empty signals exist only when FIFO_PROG_FLAG_EN is defined.
interface fifo_param_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
);
  import fifo_param_pkg::*;

  localparam int CNT_W = cntWidth(DEPTH);

  logic              wr_en;
  logic              rd_en;
  logic              flush;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic [CNT_W-1:0]  data_count;
  logic              full;
  logic              empty;
  logic              wr_ack;
  logic              wr_err;
  logic              rd_ack;
  logic              rd_err;
`ifdef FIFO_PROG_FLAG_EN
  logic              almost_full;
  logic              almost_empty;
`endif

  modport master (
    output wr_en, rd_en, flush, din,
    input  dout, data_count, full, empty, wr_ack, wr_err, rd_ack, rd_err
`ifdef FIFO_PROG_FLAG_EN
    , input almost_full, almost_empty
`endif
  );

  modport slave (
    input  wr_en, rd_en, flush, din,
    output dout, data_count, full, empty, wr_ack, wr_err, rd_ack, rd_err
`ifdef FIFO_PROG_FLAG_EN
    , output almost_full, almost_empty
`endif
  );

endinterface

// File: rtl/fifo_param_ram.sv
// DEPTH x DATA_W storage array: one synchronous write port, one asynchronous read port.
module fifo_param_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wAddr,
  input  logic [DATA_W-1:0] wData,
  input  logic [ADDR_W-1:0] rAddr,
  output logic [DATA_W-1:0] rData
);

  logic [DATA_W-1:0] mem [DEPTH];

  // No reset: the pointer logic guarantees an entry is written before it is read.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wAddr] <= wData;
    end
  end

  assign rData = mem[rAddr];

endmodule

// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with registered dout, per-request ack/err and sync flush.
// Define FIFO_PROG_FLAG_EN to add the almost_full/almost_empty programmable flags.
module fifo_param #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  fifo_param_if.slave  bus
);
  import fifo_param_pkg::*;

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = cntWidth(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || AF_LEVEL > DEPTH || AE_LEVEL > DEPTH)
  begin : g_badParams
    $error("fifo_param: DEPTH must be a power of two >= 2 and flag levels within 0..DEPTH");
  end

  logic [ADDR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] dout_q, dout_d, rData;
  op_e               op_q, op_d;
  logic              wrErr_q, wrErr_d, rdErr_q, rdErr_d;
  logic              full, empty, wrAcc, rdAcc;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  // A write into a full FIFO still succeeds when a read frees the oldest slot this edge.
  assign rdAcc = !bus.flush && bus.rd_en && !empty;
  assign wrAcc = !bus.flush && bus.wr_en && (!full || bus.rd_en);

  fifo_param_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (wrAcc),
    .wAddr (tail_q),
    .wData (bus.din),
    .rAddr (head_q),
    .rData (rData)
  );

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    dout_d  = '0;
    op_d    = OP_IDLE;
    wrErr_d = 1'b0;
    rdErr_d = 1'b0;
    if (bus.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      op_d    = OP_FLUSH;
    end else begin
      wrErr_d = bus.wr_en && !wrAcc;
      rdErr_d = bus.rd_en && !rdAcc;
      count_d = count_q + CNT_W'(wrAcc) - CNT_W'(rdAcc);
      if (wrAcc) begin
        tail_d = tail_q + ADDR_W'(1);
      end
      if (rdAcc) begin
        head_d = head_q + ADDR_W'(1);
        dout_d = rData;
      end
      case ({wrAcc, rdAcc})
        2'b10:   op_d = OP_WR;
        2'b01:   op_d = OP_RD;
        2'b11:   op_d = OP_WRRD;
        default: op_d = OP_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      dout_q  <= '0;
      op_q    <= OP_IDLE;
      wrErr_q <= 1'b0;
      rdErr_q <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      dout_q  <= dout_d;
      op_q    <= op_d;
      wrErr_q <= wrErr_d;
      rdErr_q <= rdErr_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.data_count = count_q;
  assign bus.full       = full;
  assign bus.empty      = empty;
  assign bus.wr_ack     = (op_q == OP_WR) || (op_q == OP_WRRD);
  assign bus.rd_ack     = (op_q == OP_RD) || (op_q == OP_WRRD);
  assign bus.wr_err     = wrErr_q;
  assign bus.rd_err     = rdErr_q;

`ifdef FIFO_PROG_FLAG_EN
  assign bus.almost_full  = (count_q >= CNT_W'(AF_LEVEL));
  assign bus.almost_empty = (count_q <= CNT_W'(AE_LEVEL));
`endif

endmodule

// File: tb/tb_fifo_param.sv
// Scoreboard bench for fifo_param (DEPTH=8, DATA_W=32): directed requests queue their
// hand-computed responses, and a negedge monitor compares them one cycle later.
module tb_fifo_param;

  typedef struct {
    logic        wrAck;
    logic        wrErr;
    logic        rdAck;
    logic        rdErr;
    logic [31:0] dout;
    int          count;
    int          due;
    string       name;
  } exp_t;

  logic  clk;
  logic  reset_n;
  int    cycleCnt;
  int    testsRun;
  int    testsFailed;
  exp_t  expQ[$];

  fifo_param_if #(.DATA_W(32), .DEPTH(8)) bus ();

  fifo_param #(
    .DATA_W   (32),
    .DEPTH    (8),
    .AF_LEVEL (6),
    .AE_LEVEL (2)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cycleCnt = 0;
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one request for a single cycle and queue the response it must produce.
  task automatic applyStimulus(input logic wr, input logic rd, input logic fl,
                               input logic [31:0] d,
                               input logic eWa, input logic eWe,
                               input logic eRa, input logic eRe,
                               input logic [31:0] eDout, input int eCnt,
                               input string name);
    exp_t e;
    @(negedge clk);
    bus.wr_en = wr;
    bus.rd_en = rd;
    bus.flush = fl;
    bus.din   = d;
    e.wrAck = eWa;
    e.wrErr = eWe;
    e.rdAck = eRa;
    e.rdErr = eRe;
    e.dout  = eDout;
    e.count = eCnt;
    e.due   = cycleCnt + 1;
    e.name  = name;
    expQ.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (expQ.size() > 0 && expQ[0].due <= cycleCnt) begin
        e = expQ.pop_front();
        if (e.due < cycleCnt) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL %s stale: due cycle %0d, checked at %0d", e.name, e.due, cycleCnt);
        end else begin
          checkOutput({e.name, " wr_ack"}, 32'(bus.wr_ack), 32'(e.wrAck));
          checkOutput({e.name, " wr_err"}, 32'(bus.wr_err), 32'(e.wrErr));
          checkOutput({e.name, " rd_ack"}, 32'(bus.rd_ack), 32'(e.rdAck));
          checkOutput({e.name, " rd_err"}, 32'(bus.rd_err), 32'(e.rdErr));
          checkOutput({e.name, " dout"}, bus.dout, e.dout);
          checkOutput({e.name, " count"}, 32'(bus.data_count), 32'(e.count));
          checkOutput({e.name, " full"}, 32'(bus.full), 32'(e.count == 8));
          checkOutput({e.name, " empty"}, 32'(bus.empty), 32'(e.count == 0));
`ifdef FIFO_PROG_FLAG_EN
          checkOutput({e.name, " almost_full"}, 32'(bus.almost_full), 32'(e.count >= 6));
          checkOutput({e.name, " almost_empty"}, 32'(bus.almost_empty), 32'(e.count <= 2));
`endif
        end
      end
    end
  end

  initial begin : stimulus
    testsRun    = 0;
    testsFailed = 0;
    reset_n     = 1'b0;
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.flush   = 1'b0;
    bus.din     = '0;

    repeat (2) @(negedge clk);
    checkOutput("reset dout", bus.dout, 32'h0);
    checkOutput("reset count", 32'(bus.data_count), 32'd0);
    checkOutput("reset empty", 32'(bus.empty), 32'd1);
    checkOutput("reset full", 32'(bus.full), 32'd0);
    checkOutput("reset acks", 32'({bus.wr_ack, bus.wr_err, bus.rd_ack, bus.rd_err}), 32'd0);
`ifdef FIFO_PROG_FLAG_EN
    checkOutput("reset almost_empty", 32'(bus.almost_empty), 32'd1);
    checkOutput("reset almost_full", 32'(bus.almost_full), 32'd0);
`endif
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++)
      applyStimulus(1, 0, 0, 32'((i + 1) * 'h11), 1, 0, 0, 0, 32'h0, i + 1, "fill");
    applyStimulus(1, 0, 0, 32'h99, 0, 1, 0, 0, 32'h0, 8, "overflow");
    for (int i = 0; i < 8; i++)
      applyStimulus(0, 1, 0, 32'h0, 0, 0, 1, 0, 32'((i + 1) * 'h11), 7 - i, "drain");

    applyStimulus(0, 1, 0, 32'h0, 0, 0, 0, 1, 32'h0, 0, "empty read");
    applyStimulus(1, 1, 0, 32'hA5, 1, 0, 0, 1, 32'h0, 1, "empty both");
    applyStimulus(0, 1, 0, 32'h0, 0, 0, 1, 0, 32'hA5, 0, "readback A5");

    for (int i = 0; i < 8; i++)
      applyStimulus(1, 0, 0, 32'(32'h100 + i), 1, 0, 0, 0, 32'h0, i + 1, "refill");
    applyStimulus(1, 1, 0, 32'hBEEF, 1, 0, 1, 0, 32'h100, 8, "full both");
    for (int i = 0; i < 7; i++)
      applyStimulus(0, 1, 0, 32'h0, 0, 0, 1, 0, 32'(32'h101 + i), 7 - i, "full drain");
    applyStimulus(0, 1, 0, 32'h0, 0, 0, 1, 0, 32'hBEEF, 0, "last BEEF");

    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 0, 0, 32'(32'h200 + i), 1, 0, 0, 0, 32'h0, 1, "wrap write");
      applyStimulus(0, 1, 0, 32'h0, 0, 0, 1, 0, 32'(32'h200 + i), 0, "wrap read");
    end

    for (int i = 0; i < 5; i++)
      applyStimulus(1, 0, 0, 32'(32'h300 + i), 1, 0, 0, 0, 32'h0, i + 1, "preflush");
    applyStimulus(1, 1, 1, 32'h3FF, 0, 0, 0, 0, 32'h0, 0, "flush");
    applyStimulus(0, 1, 0, 32'h0, 0, 0, 0, 1, 32'h0, 0, "postflush read");
    applyStimulus(1, 0, 0, 32'h3AA, 1, 0, 0, 0, 32'h0, 1, "postflush write");
    applyStimulus(0, 1, 0, 32'h0, 0, 0, 1, 0, 32'h3AA, 0, "postflush readback");

    // Asynchronous reset while a read result is still on dout.
    applyStimulus(1, 0, 0, 32'h401, 1, 0, 0, 0, 32'h0, 1, "prereset write1");
    applyStimulus(1, 0, 0, 32'h402, 1, 0, 0, 0, 32'h0, 2, "prereset write2");
    applyStimulus(0, 1, 0, 32'h0, 0, 0, 1, 0, 32'h401, 1, "prereset read");
    @(negedge clk);
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async reset dout", bus.dout, 32'h0);
    checkOutput("async reset count", 32'(bus.data_count), 32'd0);
    checkOutput("async reset empty", 32'(bus.empty), 32'd1);
    checkOutput("async reset rd_ack", 32'(bus.rd_ack), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(1, 0, 0, 32'h4AA, 1, 0, 0, 0, 32'h0, 1, "postreset write");
    applyStimulus(0, 1, 0, 32'h0, 0, 0, 1, 0, 32'h4AA, 0, "postreset read");
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0, "idle");

    for (int i = 0; i < 10 && expQ.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (expQ.size() > 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL scoreboard drain: %0d responses pending, expected 0", expQ.size());
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
